rat_alu_seq: RTL
================

Name: rat_alu_seq

Overview:
Registered, parametrised next-generation RAT ALU with internal C/Z flag registers, so CIN comes from the C flag rather than a port. It adds a shadow-flag save/restore for interrupt entry and return. It adds an iterative shift-add unsigned multiply as opcode 15. It sits between the register file and the control unit, which drives START/SEL and waits on DONE.

Parameters:
WIDTH, 8, datapath width in bits (>=4)
MUL_EN, 1, 1 = opcode 15 is MUL; 0 = opcode 15 is a 1-cycle NOP (flags and RESULT unchanged)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
START  in  1  accept op on SEL/A/B this cycle when not BUSY
SEL  in  4  opcode: 0 ADD,1 ADDC,2 SUB,3 SUBC,4 CMP,5 AND,6 OR,7 EXOR,8 TEST,9 LSL,10 LSR,11 ROL,12 ROR,13 ASR,14 MOV,15 MUL
A  in  WIDTH  operand A
B  in  WIDTH  operand B
FLG_SAVE  in  1  copy C/Z flags into shadow
FLG_RESTORE  in  1  copy shadow into C/Z flags
RESULT  out  WIDTH  registered result (low half for MUL)
RESULT_HI  out  WIDTH  registered MUL high half; 0 after any non-MUL result-writing op
C_FLAG  out  1  carry/borrow flag register
Z_FLAG  out  1  zero flag register
BUSY  out  1  high while MUL iterating
DONE  out  1  one-cycle pulse when an op's results/flags are visible

Behaviour:
- Reset: RESULT, RESULT_HI, C_FLAG, Z_FLAG, shadow C/Z, BUSY and DONE all 0; FSM returns to IDLE. Reset mid-MUL aborts the op; no DONE is issued.
- FSM states: IDLE, MUL_RUN.
- IDLE + START + SEL!=15: compute combinationally and register at that edge. RESULT/flags are valid and DONE=1 in the following cycle, giving 1-cycle latency. Back-to-back STARTs are allowed.
- IDLE + START + SEL==15 (MUL_EN=1): latch A and B, clear the accumulator, go to MUL_RUN with BUSY=1.
- MUL_RUN: one shift-add step per cycle for WIDTH cycles, then return to IDLE with BUSY=0. DONE pulses WIDTH+1 cycles after the START edge.
- START while BUSY is ignored, with no queueing.
- FLG_SAVE/FLG_RESTORE act in any state.
- Op rules; cin = current C_FLAG; Z = (written value == 0) unless stated:
  - ADD/ADDC: {C,R} = A+B(+cin).
  - SUB/SUBC: {C,R} = A-B(-cin), C = borrow.
  - CMP: SUB flags only; RESULT/RESULT_HI are held.
  - AND/OR/EXOR: C=0.
  - TEST: flags of A&B with C=0; RESULT/RESULT_HI are held.
  - LSL: R={A[W-2:0],cin}, C=A[W-1].
  - LSR: R={cin,A[W-1:1]}, C=A[0].
  - ROL: R={A[W-2:0],A[W-1]}, C=A[W-1].
  - ROR: R={A[0],A[W-1:1]}, C=A[0].
  - ASR: R={A[W-1],A[W-1:1]}, C=A[0].
  - MOV: R=B; flags are unchanged.
  - MUL: {RESULT_HI,RESULT} = A*B unsigned; C = |RESULT_HI; Z = (full 2W product == 0).
- Simultaneous events: FLG_RESTORE has priority over an op's flag write in the same edge. FLG_SAVE captures the pre-edge flag values. If SAVE and RESTORE are both asserted, the flags take the old shadow and the shadow takes the old flags (swap).

Decomposition:
- Package rat_alu_pkg holds the opcode enum alu_op_t (4-bit, values as above), the FSM state enum, and a flags struct {c,z}.
- One sub-module, rat_alu_comb: the combinational single-cycle op core (A, B, cin, SEL -> R, C, Z, wr_result, wr_flags).
- rat_alu_seq owns the registers, the shadow flags and the MUL FSM.

Test Plan:
1. From reset, ADD A=AA B=AA -> next cycle RESULT=54, C=1, Z=0, DONE=1 for exactly 1 cycle. Then ADDC A=0A B=A0 -> RESULT=AB, C=0.
2. SUB A=64 B=C8 -> RESULT=9C, C=1. Then CMP A=AA B=AA -> Z=1, C=0, RESULT stays 9C.
3. MUL A=C8 B=64 -> BUSY for 8 cycles, DONE 9 cycles after START, RESULT=20, RESULT_HI=4E, C=1, Z=0. A START pulse (ADD 01+01) mid-BUSY has no effect.
4. Shifts with C=1: LSR A=80 -> C0, C=0. ROR A=01 -> 80, C=1. ASR A=80 -> C0, C=0. MOV B=00 leaves Z/C unchanged.
5. Set C=1 Z=0, pulse FLG_SAVE, then AND A=AA B=55 (Z=1, C=0), then FLG_RESTORE -> C=1, Z=0. FLG_RESTORE in the same cycle as an op's completing edge -> shadow values win.
6. RST asserted on MUL cycle 4 -> next cycle all outputs 0, BUSY=0, no DONE. WIDTH=16 instance: ADD FFFF+0001 -> 0000, C=1, Z=1.

Source files
------------

// File: rtl/rat_alu_pkg.sv
// Shared types for the RAT ALU: opcode encoding, sequencer states and the flag pair.
package rat_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_EXOR = 4'd7,
    OP_TEST = 4'd8,
    OP_LSL  = 4'd9,
    OP_LSR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_ASR  = 4'd13,
    OP_MOV  = 4'd14,
    OP_MUL  = 4'd15
  } alu_op_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

endpackage

// File: rtl/rat_alu_comb.sv
// Single-cycle RAT ALU core: computes result, flags and which of them the op writes.
module rat_alu_comb
  import rat_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  alu_op_t          sel,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             z,
  output logic             wr_result,
  output logic             wr_flags
);

  localparam int EW = WIDTH + 1;

  logic [WIDTH:0] ext;

  always_comb begin
    ext       = '0;
    r         = '0;
    c         = 1'b0;
    wr_result = 1'b0;
    wr_flags  = 1'b0;
    case (sel)
      OP_ADD, OP_ADDC: begin
        ext       = {1'b0, a} + {1'b0, b} + EW'(cin & (sel == OP_ADDC));
        r         = ext[WIDTH-1:0];
        c         = ext[WIDTH];
        wr_result = 1'b1;
        wr_flags  = 1'b1;
      end
      // The extra top bit of the (WIDTH+1)-bit difference is the borrow.
      OP_SUB, OP_SUBC, OP_CMP: begin
        ext       = {1'b0, a} - {1'b0, b} - EW'(cin & (sel == OP_SUBC));
        r         = ext[WIDTH-1:0];
        c         = ext[WIDTH];
        wr_result = (sel != OP_CMP);
        wr_flags  = 1'b1;
      end
      OP_AND, OP_TEST: begin
        r         = a & b;
        wr_result = (sel == OP_AND);
        wr_flags  = 1'b1;
      end
      OP_OR: begin
        r         = a | b;
        wr_result = 1'b1;
        wr_flags  = 1'b1;
      end
      OP_EXOR: begin
        r         = a ^ b;
        wr_result = 1'b1;
        wr_flags  = 1'b1;
      end
      OP_LSL: begin
        r         = {a[WIDTH-2:0], cin};
        c         = a[WIDTH-1];
        wr_result = 1'b1;
        wr_flags  = 1'b1;
      end
      OP_LSR: begin
        r         = {cin, a[WIDTH-1:1]};
        c         = a[0];
        wr_result = 1'b1;
        wr_flags  = 1'b1;
      end
      OP_ROL: begin
        r         = {a[WIDTH-2:0], a[WIDTH-1]};
        c         = a[WIDTH-1];
        wr_result = 1'b1;
        wr_flags  = 1'b1;
      end
      OP_ROR: begin
        r         = {a[0], a[WIDTH-1:1]};
        c         = a[0];
        wr_result = 1'b1;
        wr_flags  = 1'b1;
      end
      OP_ASR: begin
        r         = {a[WIDTH-1], a[WIDTH-1:1]};
        c         = a[0];
        wr_result = 1'b1;
        wr_flags  = 1'b1;
      end
      OP_MOV: begin
        r         = b;
        wr_result = 1'b1;
      end
      default: ;
    endcase
    z = (r == '0);
  end

endmodule

// File: rtl/rat_alu_seq.sv
// Registered RAT ALU with internal C/Z flags, shadow flag save/restore and an
// iterative shift-add multiplier on opcode 15.
module rat_alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       SEL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             FLG_SAVE,
  input  logic             FLG_RESTORE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             C_FLAG,
  output logic             Z_FLAG,
  output logic             BUSY,
  output logic             DONE
);

  import rat_alu_pkg::*;

  localparam int            PW   = 2 * WIDTH;
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  flags_t           flags, shadow, flags_next;
  alu_op_t          op;
  logic [PW-1:0]    mcand, acc, acc_step;
  logic [WIDTH-1:0] mplier, core_r;
  logic [CW-1:0]    cnt;
  logic             core_c, core_z, core_wr_result, core_wr_flags;
  logic             accept, mul_start, mul_last, single_op;

  rat_alu_comb #(.WIDTH(WIDTH)) u_core (
    .a         (A),
    .b         (B),
    .cin       (flags.c),
    .sel       (op),
    .r         (core_r),
    .c         (core_c),
    .z         (core_z),
    .wr_result (core_wr_result),
    .wr_flags  (core_wr_flags)
  );

  // With MUL_EN=0 opcode 15 falls through the core as a write-nothing op.
  always_comb begin
    op         = alu_op_t'(SEL);
    accept     = (state == ST_IDLE) && START;
    mul_start  = accept && (op == OP_MUL) && MUL_EN;
    single_op  = accept && !mul_start;
    mul_last   = (state == ST_MUL_RUN) && (cnt == LAST);
    acc_step   = mplier[0] ? acc + mcand : acc;
    flags_next = flags;
    if (single_op && core_wr_flags) begin
      flags_next.c = core_c;
      flags_next.z = core_z;
    end
    if (mul_last) begin
      flags_next.c = |acc_step[PW-1:WIDTH];
      flags_next.z = (acc_step == '0);
    end
  end

  always_comb begin
    state_next = state;
    BUSY       = (state == ST_MUL_RUN);
    case (state)
      ST_IDLE:    if (mul_start) state_next = ST_MUL_RUN;
      ST_MUL_RUN: if (mul_last)  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RESULT    <= '0;
      RESULT_HI <= '0;
      flags     <= '0;
      shadow    <= '0;
      DONE      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      DONE <= single_op || mul_last;
      if (single_op && core_wr_result) begin
        RESULT    <= core_r;
        RESULT_HI <= '0;
      end
      if (mul_start) begin
        mcand  <= PW'(A);
        mplier <= B;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == ST_MUL_RUN) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
      if (mul_last) begin
        RESULT    <= acc_step[WIDTH-1:0];
        RESULT_HI <= acc_step[PW-1:WIDTH];
      end
      // Restore beats any op flag write; save/restore together swap.
      flags <= FLG_RESTORE ? shadow : flags_next;
      if (FLG_SAVE) shadow <= flags;
    end
  end

  always_comb begin
    C_FLAG = flags.c;
    Z_FLAG = flags.z;
  end

endmodule
